// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator.
// Pixel divider, h/v counters and registered sync, DE, coordinate and pulse outputs.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       DE,
   output logic [9:0] x_pixel,
   output logic [9:0] y_pixel,
   output logic       frame_start,
   output logic       line_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic        SYNC_ON  = SYNC_POL;
   localparam logic        SYNC_OFF = ~SYNC_POL;
   localparam logic        TICK_RST = (CLK_DIV == 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             pix_tick_q, pix_tick_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             frame_start_q, frame_start_d;
   logic             line_start_q, line_start_d;
   logic             h_in_sync, v_in_sync;

   always_comb begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      pix_tick_d = (div_d == DIV_MAX);

      h_d = h_q;
      v_d = v_q;
      if (pix_tick_q) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end

      // Decode the next position so outputs land on the same edge as the counters.
      de_d = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
      x_d  = de_d ? h_d : '0;
      y_d  = de_d ? v_d : '0;

      h_in_sync = ({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END);
      v_in_sync = ({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END);
      hsync_d   = h_in_sync ? SYNC_ON : SYNC_OFF;
      vsync_d   = v_in_sync ? SYNC_ON : SYNC_OFF;

      frame_start_d = pix_tick_q && (h_d == '0) && (v_d == '0);
      line_start_d  = pix_tick_q && (h_d == '0) && ({1'b0, v_d} < V_VIS);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q         <= '0;
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         pix_tick_q    <= TICK_RST;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pix_tick_q    <= pix_tick_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign pix_tick    = pix_tick_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign DE          = de_q;
   assign x_pixel     = x_q;
   assign y_pixel     = y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster.
// Two instances: CLK_DIV=4 and CLK_DIV=1, same 15x10 geometry.
module tb_vga_timing_gen;

   localparam int HT = 15;
   localparam int VT = 10;
   localparam int HV = 8;
   localparam int VV = 6;

   typedef struct packed {
      int          n;
      logic [25:0] ea;
      logic [25:0] eb;
   } exp_t;

   logic clk;
   logic reset_n;

   logic       a_tick, a_hs, a_vs, a_de, a_fs, a_ls;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_hs, b_vs, b_de, b_fs, b_ls;
   logic [9:0] b_x, b_y;

   exp_t q[$];
   int total;
   int bad;

   vga_timing_gen #(
      .CLK_DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .pix_tick(a_tick),
      .hsync(a_hs), .vsync(a_vs), .DE(a_de),
      .x_pixel(a_x), .y_pixel(a_y),
      .frame_start(a_fs), .line_start(a_ls)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .pix_tick(b_tick),
      .hsync(b_hs), .vsync(b_vs), .DE(b_de),
      .x_pixel(b_x), .y_pixel(b_y),
      .frame_start(b_fs), .line_start(b_ls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n = number of non-reset edges since the last reset edge.
   function automatic logic [25:0] model(input int n, input int d);
      int k, l, h, v;
      logic pix, de, hs, vs, fs, ls, adv;
      logic [9:0] x, y;
      pix = ((n % d) == d - 1);
      k = n / d;
      if (k == 0) return {pix, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
      l = (k - 1) % (HT * VT);
      h = l % HT;
      v = l / HT;
      de = (h < HV) && (v < VV);
      x = de ? 10'(h) : 10'd0;
      y = de ? 10'(v) : 10'd0;
      hs = !((h >= 10) && (h < 13));
      vs = !((v >= 7) && (v < 9));
      adv = ((n % d) == 0);
      fs = adv && (l == 0);
      ls = adv && (h == 0) && (v < VV);
      return {pix, hs, vs, de, x, y, fs, ls};
   endfunction

   int n_edges;

   task automatic step();
      exp_t e;
      @(posedge clk);
      if (!reset_n) n_edges = 0;
      else n_edges++;
      e.n  = n_edges;
      e.ea = model(n_edges, 4);
      e.eb = model(n_edges, 1);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input int got, input int req);
      total++;
      if (got != req) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   int  acc_clk[2], acc_ls[2], acc_de[2], acc_hs[2], acc_vs[2];
   int  frames[2];
   bit  win[2];
   int  per_req[2] = '{600, 150};
   int  de_req[2]  = '{192, 48};
   int  hs_req[2]  = '{120, 30};

   task automatic agg(input int i, input logic [25:0] act);
      if (act[1]) begin
         if (win[i]) begin
            chk($sformatf("dut%0d frame_period", i), acc_clk[i], per_req[i]);
            chk($sformatf("dut%0d line_starts", i), acc_ls[i], 6);
            chk($sformatf("dut%0d de_clks", i), acc_de[i], de_req[i]);
            chk($sformatf("dut%0d hsync_low", i), acc_hs[i], hs_req[i]);
            chk($sformatf("dut%0d vsync_low", i), acc_vs[i], hs_req[i]);
            frames[i]++;
         end
         acc_clk[i] = 0;
         acc_ls[i]  = 0;
         acc_de[i]  = 0;
         acc_hs[i]  = 0;
         acc_vs[i]  = 0;
         win[i]     = 1'b1;
      end
      acc_clk[i]++;
      acc_ls[i] += int'(act[0]);
      acc_de[i] += int'(act[22]);
      acc_hs[i] += int'(!act[24]);
      acc_vs[i] += int'(!act[23]);
   endtask

   initial begin : monitor
      exp_t e;
      logic [25:0] aa, ab;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            aa = {a_tick, a_hs, a_vs, a_de, a_x, a_y, a_fs, a_ls};
            ab = {b_tick, b_hs, b_vs, b_de, b_x, b_y, b_fs, b_ls};
            total += 2;
            if (aa !== e.ea) begin
               bad++;
               $display("FAIL div4_vec n=%0d got=%h required=%h", e.n, aa, e.ea);
            end
            if (ab !== e.eb) begin
               bad++;
               $display("FAIL div1_vec n=%0d got=%h required=%h", e.n, ab, e.eb);
            end
            if (e.n == 0) begin
               win[0] = 1'b0;
               win[1] = 1'b0;
            end else begin
               agg(0, aa);
               agg(1, ab);
            end
         end
      end
   end

   initial begin : stim
      total = 0;
      bad = 0;
      n_edges = 0;
      reset_n = 1'b0;
      repeat (5) step();
      reset_n = 1'b1;
      repeat (1285) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (700) step();
      #1;
      chk("queue_drained", q.size(), 0);
      chk("div4_frames_checked", frames[0], 3);
      chk("div1_frames_checked", frames[1], 12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
